// File: rtl/wb_dcache_pkg.sv
// Shared types and default geometry for the write-back data cache.
// Optional statistics counters are enabled with WB_DCACHE_STATS_EN.
package wb_dcache_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_LINES  = 8;
  localparam int DEF_WORDS  = 4;

  localparam int OFFSET_W = $clog2(DEF_WORDS);
  localparam int INDEX_W  = $clog2(DEF_LINES);
  localparam int TAG_W    = DEF_ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;
endpackage

// File: rtl/wb_dcache_line_store.sv
// Direct-mapped line storage: data, tag, valid and dirty per line.
// Asynchronous read of the indexed line, synchronous word write or full-line fill.
module wb_dcache_line_store #(
  parameter int DATA_W = 8,
  parameter int LINES  = 8,
  parameter int WORDS  = 4,
  parameter int TAG_W  = 3,
  parameter int IDX_W  = $clog2(LINES),
  parameter int OFF_W  = $clog2(WORDS)
)(
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [IDX_W-1:0]             idx,
  input  logic [OFF_W-1:0]             off,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         fill_en,
  input  logic [TAG_W-1:0]             fill_tag,
  input  logic [WORDS-1:0][DATA_W-1:0] fill_data,
  output logic                         valid,
  output logic                         dirty,
  output logic [TAG_W-1:0]             tag,
  output logic [WORDS-1:0][DATA_W-1:0] block
);
  logic [LINES-1:0]             valid_r, dirty_r;
  logic [TAG_W-1:0]             tag_r  [LINES];
  logic [WORDS-1:0][DATA_W-1:0] data_r [LINES];

  assign valid = valid_r[idx];
  assign dirty = dirty_r[idx];
  assign tag   = tag_r[idx];
  assign block = data_r[idx];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_r <= '0;
      dirty_r <= '0;
    end else if (fill_en) begin
      valid_r[idx] <= 1'b1;
      dirty_r[idx] <= 1'b0;
    end else if (wr_en) begin
      dirty_r[idx] <= 1'b1;
    end
  end

  // Payload needs no reset; valid gates every use of it.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_r[idx]  <= fill_tag;
      data_r[idx] <= fill_data;
    end else if (wr_en) begin
      data_r[idx][off] <= wr_data;
    end
  end
endmodule

// File: rtl/wb_dcache.sv
// Direct-mapped, write-back, write-allocate data cache with a block memory port.
// Define WB_DCACHE_STATS_EN to add saturating HIT/MISS/WB counters.
module wb_dcache
  import wb_dcache_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINES  = DEF_LINES,
  parameter int WORDS  = DEF_WORDS
)(
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               READ,
  input  logic                               WRITE,
  input  logic [ADDR_W-1:0]                  ADDRESS,
  input  logic [DATA_W-1:0]                  WRITEDATA,
  output logic [DATA_W-1:0]                  READDATA,
  output logic                               BUSYWAIT,
  output logic                               MEM_READ,
  output logic                               MEM_WRITE,
  output logic [ADDR_W-$clog2(WORDS)-1:0]    MEM_ADDRESS,
  output logic [DATA_W*WORDS-1:0]            MEM_WRITEDATA,
  input  logic [DATA_W*WORDS-1:0]            MEM_READDATA,
  input  logic                               MEM_BUSYWAIT
`ifdef WB_DCACHE_STATS_EN
  ,
  output logic [15:0]                        HIT_COUNT,
  output logic [15:0]                        MISS_COUNT,
  output logic [15:0]                        WB_COUNT
`endif
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TG_W  = ADDR_W - IDX_W - OFF_W;

  logic [TG_W-1:0]              tag_a, l_tag;
  logic [IDX_W-1:0]             idx_a;
  logic [OFF_W-1:0]             off_a;
  logic                         req, hit, l_valid, l_dirty, wr_en, fill_en;
  logic [WORDS-1:0][DATA_W-1:0] l_block, fill_buf;
  state_t                       state, next_state;

  assign {tag_a, idx_a, off_a} = ADDRESS;
  assign req = READ | WRITE;
  assign hit = l_valid && (l_tag == tag_a);

  wb_dcache_line_store #(
    .DATA_W(DATA_W), .LINES(LINES), .WORDS(WORDS), .TAG_W(TG_W),
    .IDX_W(IDX_W), .OFF_W(OFF_W)
  ) u_store (
    .CLK(CLK), .RESET(RESET), .idx(idx_a), .off(off_a),
    .wr_en(wr_en), .wr_data(WRITEDATA),
    .fill_en(fill_en), .fill_tag(tag_a), .fill_data(fill_buf),
    .valid(l_valid), .dirty(l_dirty), .tag(l_tag), .block(l_block)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // Memory data is only guaranteed while MEM_READ is up, so latch it for UPDATE.
  always_ff @(posedge CLK) begin
    if (state == FETCH && !MEM_BUSYWAIT) fill_buf <= MEM_READDATA;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (req && !hit) next_state = (l_valid && l_dirty) ? WRITEBACK : FETCH;
      WRITEBACK: if (!MEM_BUSYWAIT) next_state = FETCH;
      FETCH:     if (!MEM_BUSYWAIT) next_state = UPDATE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    READDATA      = '0;
    wr_en         = 1'b0;
    fill_en       = 1'b0;
    if (!RESET) begin
      READDATA = l_block[off_a];
      BUSYWAIT = req && !(state == IDLE && hit);
      case (state)
        IDLE:      wr_en = WRITE && hit;
        WRITEBACK: begin
          MEM_WRITE     = 1'b1;
          MEM_ADDRESS   = {l_tag, idx_a};
          MEM_WRITEDATA = l_block;
        end
        FETCH: begin
          MEM_READ    = 1'b1;
          MEM_ADDRESS = {tag_a, idx_a};
        end
        default:   fill_en = 1'b1;
      endcase
    end
  end

`ifdef WB_DCACHE_STATS_EN
  // The hit right after a fill belongs to the miss, not to HIT_COUNT.
  logic post_fill;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      post_fill  <= 1'b0;
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
      WB_COUNT   <= '0;
    end else begin
      post_fill <= (state == UPDATE);
      if (state == IDLE && req && hit && !post_fill && HIT_COUNT != 16'hFFFF)
        HIT_COUNT <= HIT_COUNT + 16'd1;
      if (state == IDLE && req && !hit && MISS_COUNT != 16'hFFFF)
        MISS_COUNT <= MISS_COUNT + 16'd1;
      if (state == IDLE && next_state == WRITEBACK && WB_COUNT != 16'hFFFF)
        WB_COUNT <= WB_COUNT + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_wb_dcache.sv
// Directed plus randomized bench for wb_dcache against a flat-memory reference.
// Build with WB_DCACHE_STATS_EN to also check the statistics counters.
module tb_wb_dcache;
  localparam int DW = 8, AW = 8, NW = 4, BW = DW*NW, MAW = AW-2;

  logic CLK = 1'b0, RESET = 1'b1, READ = 1'b0, WRITE = 1'b0;
  logic [AW-1:0]  ADDRESS = '0;
  logic [DW-1:0]  WRITEDATA = '0, READDATA;
  logic           BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [MAW-1:0] MEM_ADDRESS;
  logic [BW-1:0]  MEM_WRITEDATA, MEM_READDATA;
`ifdef WB_DCACHE_STATS_EN
  logic [15:0] HIT_COUNT, MISS_COUNT, WB_COUNT;
`endif

  wb_dcache dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef WB_DCACHE_STATS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT), .WB_COUNT(WB_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Block memory: a request completes in the lat-th cycle it is held.
  logic [BW-1:0]  mem_blk [64];
  bit             mem_wr  [64];
  int             mcnt = 0, wb_n = 0, rd_n = 0, lat = 5, overlap_n = 0;
  logic [MAW-1:0] wb_addr = '0, rd_addr = '0;
  logic [BW-1:0]  wb_data = '0;

  function automatic logic [BW-1:0] init_blk(input int b);
    logic [BW-1:0] r;
    for (int w = 0; w < NW; w++) r[w*DW +: DW] = 8'(b*29 + w*13 + 7);
    return r;
  endfunction

  function automatic logic [DW-1:0] backing_word(input int a);
    logic [BW-1:0] blk;
    blk = mem_wr[a/4] ? mem_blk[a/4] : init_blk(a/4);
    return blk[(a%4)*DW +: DW];
  endfunction

  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mcnt != lat - 1);
  assign MEM_READDATA = !MEM_READ ? '0 :
                        (mem_wr[MEM_ADDRESS] ? mem_blk[MEM_ADDRESS] : init_blk(int'(MEM_ADDRESS)));

  always @(posedge CLK) begin
    if (MEM_WRITE && !MEM_BUSYWAIT) begin
      mem_blk[MEM_ADDRESS] <= MEM_WRITEDATA;
      mem_wr[MEM_ADDRESS]  <= 1'b1;
      wb_n    <= wb_n + 1;
      wb_addr <= MEM_ADDRESS;
      wb_data <= MEM_WRITEDATA;
    end
    if (MEM_READ && !MEM_BUSYWAIT) begin
      rd_n    <= rd_n + 1;
      rd_addr <= MEM_ADDRESS;
    end
    if ((MEM_READ || MEM_WRITE) && MEM_BUSYWAIT) mcnt <= mcnt + 1;
    else                                         mcnt <= 0;
  end

  always @(negedge CLK) if (MEM_READ && MEM_WRITE) overlap_n = overlap_n + 1;

  // Reference: the cache must look like a flat byte memory; line state only sets timing.
  logic [DW-1:0] ref_mem [256];
  bit            rv [8], rdty [8];
  int            rt [8];
  int            vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin rv[i] = 0; rdty[i] = 0; rt[i] = 0; end
    for (int a = 0; a < 256; a++) ref_mem[a] = backing_word(a);
  endtask

  // Called just after a posedge; returns just after the posedge that commits the request.
  task automatic txn(input bit rd, input bit wr, input int a, input logic [DW-1:0] d,
                     input string tag);
    int idx, tg, vblk, stall, exp_stall, wb0, rd0;
    bit hit, dv;
    logic [DW-1:0] rdata;
    logic [BW-1:0] exp_wb;
    idx  = (a / 4) % 8;
    tg   = a / 32;
    hit  = rv[idx] && rt[idx] == tg;
    dv   = !hit && rv[idx] && rdty[idx];
    exp_stall = hit ? 0 : (dv ? 2*lat + 2 : lat + 2);
    vblk = rt[idx]*8 + idx;
    for (int w = 0; w < NW; w++) exp_wb[w*DW +: DW] = ref_mem[vblk*4 + w];
    wb0 = wb_n; rd0 = rd_n;
    READ = rd; WRITE = wr; ADDRESS = 8'(a); WRITEDATA = d;
    stall = 0;
    @(negedge CLK);
    while (BUSYWAIT && stall < 200) begin stall++; @(negedge CLK); end
    rdata = READDATA;
    @(posedge CLK); #1;
    READ = 0; WRITE = 0;
    chk({tag, "_stall"}, 64'(stall), 64'(exp_stall));
    if (rd && !wr) chk({tag, "_rdata"}, 64'(rdata), 64'(ref_mem[a]));
    chk({tag, "_fetches"}, 64'(rd_n - rd0), 64'(hit ? 0 : 1));
    if (!hit) chk({tag, "_fetch_addr"}, 64'(rd_addr), 64'(tg*8 + idx));
    chk({tag, "_writebacks"}, 64'(wb_n - wb0), 64'(dv ? 1 : 0));
    if (dv) begin
      chk({tag, "_wb_addr"}, 64'(wb_addr), 64'(vblk));
      chk({tag, "_wb_data"}, 64'(wb_data), 64'(exp_wb));
    end
    if (wr) ref_mem[a] = d;
    if (!hit) begin rv[idx] = 1; rt[idx] = tg; rdty[idx] = 0; end
    if (wr) rdty[idx] = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rd0, a, op;
    // Reset with a request pending: everything must stay quiet.
    RESET = 1; READ = 1; ADDRESS = 8'h24;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busywait",  64'(BUSYWAIT), 64'(0));
    chk("rst_mem_read",  64'(MEM_READ), 64'(0));
    chk("rst_mem_write", 64'(MEM_WRITE), 64'(0));
    chk("rst_mem_addr",  64'(MEM_ADDRESS), 64'(0));
    chk("rst_mem_wdata", 64'(MEM_WRITEDATA), 64'(0));
    chk("rst_readdata",  64'(READDATA), 64'(0));
`ifdef WB_DCACHE_STATS_EN
    chk("rst_hit_count", 64'(HIT_COUNT), 64'(0));
`endif
    @(posedge CLK); #1;
    RESET = 0; READ = 0; ADDRESS = '0;
    model_reset();
    @(negedge CLK);
    chk("idle_busywait", 64'(BUSYWAIT), 64'(0));
    @(posedge CLK); #1;

    lat = 5;
    txn(1, 0, 'h00, 8'h00, "cold_read_00");
    txn(1, 0, 'h04, 8'h00, "fill_04");
    txn(0, 1, 'h05, 8'hAA, "write_hit_05");
    txn(1, 0, 'h05, 8'h00, "read_back_05");
    txn(1, 0, 'h24, 8'h00, "dirty_evict_24");
    txn(1, 1, 'h00, 8'h3C, "rw_as_write_00");
    txn(1, 0, 'h00, 8'h00, "read_after_rw");
    txn(1, 0, 'h20, 8'h00, "evict_rw_line");
    txn(0, 1, 'h24, 8'h5A, "dirty_before_rst");

    // Abort a fetch with reset; dirty line at index 1 must be discarded.
    rd0 = rd_n;
    READ = 1; ADDRESS = 8'h40;
    @(negedge CLK); chk("abort_miss_busywait", 64'(BUSYWAIT), 64'(1));
    @(negedge CLK); chk("abort_fetch_active", 64'(MEM_READ), 64'(1));
    @(posedge CLK); #1; RESET = 1;
    @(negedge CLK);
    chk("abort_mem_read",  64'(MEM_READ), 64'(0));
    chk("abort_busywait",  64'(BUSYWAIT), 64'(0));
    chk("abort_no_fill",   64'(rd_n - rd0), 64'(0));
    @(posedge CLK); #1;
    RESET = 0; READ = 0;
    model_reset();

    txn(1, 0, 'h00, 8'h00, "post_rst_miss_00");
    txn(1, 0, 'h01, 8'h00, "hit_01");
    txn(1, 0, 'h02, 8'h00, "hit_02");
    txn(1, 0, 'h03, 8'h00, "hit_03");
`ifdef WB_DCACHE_STATS_EN
    chk("hit_count",  64'(HIT_COUNT), 64'(3));
    chk("miss_count", 64'(MISS_COUNT), 64'(1));
    chk("wb_count",   64'(WB_COUNT), 64'(0));
`endif
    txn(1, 0, 'h24, 8'h00, "discarded_24");

    for (int i = 0; i < 160; i++) begin
      if (i % 32 == 0) lat = $urandom_range(1, 5);
      a  = $urandom_range(0, 2)*32 + $urandom_range(0, 31);
      op = $urandom_range(0, 2);
      txn(op != 1, op != 0, a, 8'($urandom), "rand");
    end

    chk("no_mem_overlap", 64'(overlap_n), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
